// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory port, branch redirect, halt,
// the decode-facing instruction handshake, and a debug view of occupancy.
//
// Decode handshake: w_ir_valid/w_ir/w_ir_pc/w_ir_pc4 come from registers
// only and stay stable while w_ir_valid=1 and w_ir_ready=0. An entry is
// transferred on every cycle where w_ir_valid and w_ir_ready are both high.
interface fetch_queue_if #(
    parameter int AW = 12,
    parameter int CW = 3
);
    logic [AW-1:0] w_imem_addr;
    logic          w_imem_re;
    logic [31:0]   w_imem_rdata;
    logic          w_redirect;
    logic [31:0]   w_redirect_pc;
    logic          w_halt;
    logic          w_ir_valid;
    logic          w_ir_ready;
    logic [31:0]   w_ir;
    logic [31:0]   w_ir_pc;
    logic [31:0]   w_ir_pc4;
    logic [CW-1:0] w_dbg_count;

    modport master (
        output w_imem_addr, w_imem_re, w_ir_valid, w_ir, w_ir_pc, w_ir_pc4,
               w_dbg_count,
        input  w_imem_rdata, w_redirect, w_redirect_pc, w_halt, w_ir_ready
    );

    modport slave (
        input  w_imem_addr, w_imem_re, w_ir_valid, w_ir, w_ir_pc, w_ir_pc4,
               w_dbg_count,
        output w_imem_rdata, w_redirect, w_redirect_pc, w_halt, w_ir_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential word reads into a 1-cycle
// synchronous imem, buffers returned words with their PC in a small FIFO,
// and hands them to decode. A redirect flushes the FIFO and the in-flight
// read and restarts fetch at the target.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 12,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0020;

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   ipc_q, ipc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   ent_ir_q [DEPTH];
    logic [31:0]   ent_ir_d [DEPTH];
    logic [31:0]   ent_pc_q [DEPTH];
    logic [31:0]   ent_pc_d [DEPTH];

    logic          valid;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occ_after;

    // Handshake terms; occupancy counts the in-flight read so a returning
    // word always has a free slot.
    always_comb begin
        valid     = (count_q != '0);
        pop       = valid & bus.w_ir_ready;
        push      = inflight_q & ~bus.w_redirect;
        occ_after = {1'b0, count_q} + {{CW{1'b0}}, inflight_q}
                  - {{CW{1'b0}}, pop};
        issue     = ~bus.w_halt & ~bus.w_redirect
                  & (occ_after < (CW+1)'(DEPTH));
    end

    // Next-state: redirect flushes everything, otherwise push/pop/issue.
    always_comb begin
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fpc_d      = fpc_q;
        ipc_d      = ipc_q;
        inflight_d = 1'b0;
        ent_ir_d   = ent_ir_q;
        ent_pc_d   = ent_pc_q;
        if (bus.w_redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            fpc_d    = {bus.w_redirect_pc[31:2], 2'b00};
        end else begin
            if (push) begin
                ent_ir_d[wr_ptr_q] = bus.w_imem_rdata;
                ent_pc_d[wr_ptr_q] = ipc_q;
                wr_ptr_d           = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (issue) begin
                inflight_d = 1'b1;
                ipc_d      = fpc_q;
                fpc_d      = fpc_q + 32'd4;
            end
        end
    end

    // Control and PC registers.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fpc_q      <= RESET_PC;
            ipc_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fpc_q      <= fpc_d;
            ipc_q      <= ipc_d;
            inflight_q <= inflight_d;
        end
    end

    // Queue storage.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_ir_q[i] <= NOP;
                ent_pc_q[i] <= '0;
            end
        end else begin
            ent_ir_q <= ent_ir_d;
            ent_pc_q <= ent_pc_d;
        end
    end

    // Outputs: imem port from fetch PC, decode side from head registers.
    always_comb begin
        bus.w_imem_addr = fpc_q[AW+1:2];
        bus.w_imem_re   = issue & w_rst_n;
        bus.w_ir_valid  = valid;
        bus.w_ir        = valid ? ent_ir_q[rd_ptr_q] : NOP;
        bus.w_ir_pc     = valid ? ent_pc_q[rd_ptr_q] : 32'h0;
        bus.w_ir_pc4    = valid ? (ent_pc_q[rd_ptr_q] + 32'd4) : 32'h0;
        bus.w_dbg_count = count_q;
    end
endmodule
